// File: rtl/alu_seq_if.sv
// Bundle of command, downstream-ALU and result signals for the sequenced ALU controller.
// The slave side is the controller; the master side is its environment.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_in1;
  logic [WIDTH-1:0] cmd_in2;
  logic             cmd_use_acc;

  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic [7:0]       op_cnt;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_in1, cmd_in2, cmd_use_acc, alu_out, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, op_cnt
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_in1, cmd_in2, cmd_use_acc, alu_out, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, op_cnt
  );
endinterface

// File: rtl/alu_seq.sv
// Sequences commands through an external combinational ALU: accept, issue, then hold
// the captured result until consumed. A running accumulator allows chained operations.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] resData_q, resData_d;
  logic             resErr_q, resErr_d;
  logic [7:0]       opCnt_q, opCnt_d;
  logic             selIllegal;

  assign selIllegal = (sel_q > 3'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      sel_q     <= '0;
      resData_q <= '0;
      resErr_q  <= 1'b0;
      opCnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sel_q     <= sel_d;
      resData_q <= resData_d;
      resErr_q  <= resErr_d;
      opCnt_q   <= opCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    resData_d = resData_q;
    resErr_d  = resErr_q;
    opCnt_d   = opCnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op1_d   = bus.cmd_use_acc ? acc_q : bus.cmd_in1;
          op2_d   = bus.cmd_in2;
          sel_d   = bus.cmd_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Illegal opcodes still produce a flagged result but must not disturb a chain.
        resData_d = bus.alu_out;
        resErr_d  = selIllegal;
        if (!selIllegal) begin
          acc_d = bus.alu_out;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          opCnt_d = opCnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are forced low while reset is asserted, whatever the state.
  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign bus.res_valid = (state_q == RESP) && rst_n;
  assign bus.alu_in1   = op1_q;
  assign bus.alu_in2   = op2_q;
  assign bus.alu_sel   = sel_q;
  assign bus.res_data  = resData_q;
  assign bus.res_err   = resErr_q;
  assign bus.op_cnt    = opCnt_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_sel  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor; 101-111 illegal.
REQ-007 cmd_in1  input  WIDTH  operand 1.
REQ-008 cmd_in2  input  WIDTH  operand 2.
REQ-009 cmd_use_acc  input  1  1 = substitute accumulator for operand 1 (chaining).
REQ-010 alu_in1  output  WIDTH  operand 1 driven to downstream 16-bit ALU.
REQ-011 alu_in2  output  WIDTH  operand 2 driven to ALU.
REQ-012 alu_sel  output  3  opcode driven to ALU.
REQ-013 alu_out  input  WIDTH  combinational ALU result.
REQ-014 res_valid  output  1  result present.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  WIDTH  captured result.
REQ-017 res_err  output  1  result belongs to an illegal opcode.
REQ-018 op_cnt  output  8  count of completed result handshakes.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP; no other reachable states.
REQ-020 cmd_ready SHALL be 1 only in IDLE (registered-state decode, not dependent on cmd_valid).
REQ-021 IDLE + cmd_valid: latch op1 (acc if cmd_use_acc else cmd_in1), cmd_in2, cmd_sel into operand registers; next state ISSUE.
REQ-022 IDLE without cmd_valid: remain IDLE, operand registers unchanged.
REQ-023 alu_in1/alu_in2/alu_sel SHALL be driven from operand registers in all states (stable, glitch-free between accepts).
REQ-024 ISSUE: capture alu_out into res_data; set res_err = (sel >= 101); next state RESP unconditionally.
REQ-025 ISSUE with legal sel: accumulator <= alu_out; illegal sel: accumulator unchanged.
REQ-026 res_valid SHALL be 1 exactly in RESP; res_data/res_err stable while res_valid=1 and res_ready=0.
REQ-027 RESP + res_ready: next state IDLE, op_cnt += 1 (wraps 255 -> 0); otherwise hold RESP.
REQ-028 Latency: command accepted at edge N -> res_valid=1 after edge N+1; back-to-back throughput 1 op per 3 cycles with res_ready tied 1.
REQ-029 Arithmetic is modulo 2^WIDTH (no carry/borrow output); sub = op1 - op2 wrapped.
REQ-030 cmd_use_acc reads accumulator value as of the accept edge (includes previous op's legal result).
REQ-031 cmd_valid/cmd fields ignored outside IDLE; no command is lost since cmd_ready=0 there.
REQ-032 res_ready while not in RESP SHALL have no effect.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force: state IDLE, accumulator 0, operand registers 0 (alu_in1=alu_in2=0, alu_sel=000), res_data 0, res_err 0, op_cnt 0.
REQ-034 During reset cycles outputs SHALL read: cmd_ready 0, res_valid 0; cmd_ready rises the first cycle after rst_n returns 1.
REQ-035 Reset in ISSUE or RESP SHALL abandon the operation: no result handshake, op_cnt not incremented, res_valid 0 after that edge.

Verification
REQ-036 Add: cmd in1=0x0005, in2=0x0003, sel=000, res_ready=1 -> res_data=0x0008, res_err=0, res_valid one cycle, op_cnt=1.
REQ-037 Chain: add 0xFFFF+0x0002 (res 0x0001), then use_acc=1, in2=0x0010, sel=001 -> second res_data=0xFFF1.
REQ-038 Illegal: prior acc=0x1234, sel=110 -> res_data=0x0000, res_err=1; next use_acc op sees op1=0x1234.
REQ-039 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data/res_err stable, cmd_ready=0 throughout, single handshake when res_ready=1.
REQ-040 Reset mid-RESP: drop rst_n while res_valid=1 -> next cycle res_valid=0, op_cnt=0, acc=0, alu_in1/alu_in2=0.
REQ-041 Counter wrap: 256 completed ops -> op_cnt returns to 0x00.
